// File: rtl/seq_mul_ctrl_pkg.sv
// Package mul_pkg: shared types for the sequential shift-and-add multiplier.
//   mul_state_t : controller FSM states (IDLE, RUN, DONE).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_mul_ctrl_adder.sv
// adder: plain unsigned W-bit adder, shared by the multiplier across iterations.
//   a, b : W-bit addends
//   sum  : W-bit sum (caller sizes W so no carry is dropped)
module adder #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: multi-cycle unsigned shift-and-add multiplier controller.
// One WIDTH+1 bit adder is reused over WIDTH iterations; product = {hi,lo}.
//   clk, reset         : clock, synchronous active-high reset
//   flush              : abort any operation, return to IDLE
//   in_valid/in_ready  : operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready: product handshake, product held under back-pressure
//   product            : 2*WIDTH-bit result {hi,lo}
//   busy               : high while running or holding a result
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mul_state_t        state;
  mul_state_t        state_next;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH:0]    addend;
  logic [WIDTH:0]    sum;
  logic              accept;

  adder #(.W(WIDTH + 1)) u_adder (
    .a   ({1'b0, hi}),
    .b   (addend),
    .sum (sum)
  );

  always_comb begin
    addend     = lo[0] ? {1'b0, mcand} : '0;
    accept     = (state == IDLE) && in_valid && !flush;
    state_next = state;
    unique case (state)
      IDLE:    if (accept)        state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
    // flush outranks every handshake, including a pending out_ready in DONE
    if (flush) state_next = IDLE;

    in_ready  = (state == IDLE) && !flush;
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
    product   = {hi, lo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        // hi/lo deliberately retained; they are simply never presented
        count <= '0;
      end else if (accept) begin
        mcand <= a;
        lo    <= b;
        hi    <= '0;
        count <= '0;
      end else if (state == RUN) begin
        // {sum, lo} >> 1: the adder carry lands in the hi MSB
        hi    <= sum[WIDTH:1];
        lo    <= {sum[0], lo[WIDTH-1:1]};
        count <= count + 1'b1;
      end
    end
  end

endmodule
